// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_rd1,
  output logic [WIDTH-1:0] alu_rd2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic             rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [1:0]       grant;
  logic             accept;
  logic             op_legal;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_q, last_d;
`endif

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11: grant = 2'b01;
`else
      2'b11: grant = last_q ? 2'b01 : 2'b10;
`endif
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign op_legal  = (op_q == 4'b0010) || (op_q == 4'b0110) ||
                     (op_q == 4'b0000) || (op_q == 4'b0001);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          op_d    = req_ready[1] ? req1_op : req0_op;
          a_d     = req_ready[1] ? req1_a  : req0_a;
          b_d     = req_ready[1] ? req1_b  : req0_b;
          id_d    = req_ready[1];
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = req_ready[1];
`endif
        end
      end
      EXEC: begin
        // Illegal opcodes still spend the EXEC cycle; the ALU result is discarded.
        state_d = RESP;
        data_d  = op_legal ? alu_out : '0;
        zero_d  = op_legal ? alu_zero : 1'b0;
        err_d   = !op_legal;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign alu_rd1   = (state_q == EXEC) ? a_q  : '0;
  assign alu_rd2   = (state_q == EXEC) ? b_q  : '0;
  assign alu_op    = (state_q == EXEC) ? op_q : 4'b0000;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_rd1, alu_rd2, alu_out, rsp_data;
  logic        alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;
  int          checks = 0;
  int          errors = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Shared ALU; an illegal opcode yields junk so the DUT must mask it.
  always_comb begin
    case (alu_op)
      4'b0010: alu_out = alu_rd1 + alu_rd2;
      4'b0110: alu_out = alu_rd1 - alu_rd2;
      4'b0000: alu_out = alu_rd1 & alu_rd2;
      4'b0001: alu_out = alu_rd1 | alu_rd2;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'd0) || (alu_op == 4'b1111);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string tag, input logic [1:0] v, input logic [1:0] exp_grant,
                     input logic [31:0] exp_data, input logic exp_zero, input logic exp_err);
    req_valid = v;
    rsp_ready = 1'b1;
    #1;
    chk({tag, ".grant"}, {30'd0, req_ready}, {30'd0, exp_grant});
    tick();
    #1;
    chk({tag, ".exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".exec_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, ".exec_rd1"}, alu_rd1, exp_grant[1] ? req1_a : req0_a);
    chk({tag, ".exec_op"}, {28'd0, alu_op}, {28'd0, exp_grant[1] ? req1_op : req0_op});
    tick();
    #1;
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_data"}, rsp_data, exp_data);
    chk({tag, ".rsp_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
    chk({tag, ".rsp_id"}, {31'd0, rsp_id}, {31'd0, exp_grant[1]});
    chk({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, ".resp_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, ".resp_alu_op"}, {28'd0, alu_op}, 32'd0);
    tick();
    #1;
    chk({tag, ".done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_op = 4'b0010; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 4'b0010; req1_a = 32'd0; req1_b = 32'd0;

    do_reset();
    chk("reset.req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset.rsp_data", rsp_data, 32'd0);
    chk("reset.alu_rd1", alu_rd1, 32'd0);
    chk("reset.rsp_err", {31'd0, rsp_err}, 32'd0);

    req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
    txn("add_1_1", 2'b01, 2'b01, 32'd2, 1'b0, 1'b0);

    req_valid = 2'b00;
    do_reset();
    req0_op = 4'b0010; req0_a = 32'd2;   req0_b = 32'd2;
    req1_op = 4'b0110; req1_a = 32'd143; req1_b = 32'd1293;
    txn("rr0", 2'b11, 2'b01, 32'd4, 1'b0, 1'b0);
    txn("rr1", 2'b11, 2'b10, 32'hFFFF_FB82, 1'b0, 1'b0);
    txn("rr2", 2'b11, 2'b01, 32'd4, 1'b0, 1'b0);
    txn("rr3", 2'b11, 2'b10, 32'hFFFF_FB82, 1'b0, 1'b0);

    req1_op = 4'b0110; req1_a = 32'd5; req1_b = 32'd5;
    txn("sub_zero", 2'b10, 2'b10, 32'd0, 1'b1, 1'b0);
    req0_op = 4'b0000; req0_a = 32'h33; req0_b = 32'h23;
    txn("and", 2'b01, 2'b01, 32'h23, 1'b0, 1'b0);
    req0_op = 4'b0001; req0_a = 32'h34; req0_b = 32'h39;
    txn("or", 2'b01, 2'b01, 32'h3D, 1'b0, 1'b0);

    // Backpressure: response held over three stalled cycles.
    req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd4;
    req_valid = 2'b01; rsp_ready = 1'b0;
    #1;
    chk("stall.grant", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b11;
    #1;
    chk("stall.exec_valid", {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("stall.valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall.data", rsp_data, 32'd7);
      chk("stall.id", {31'd0, rsp_id}, 32'd0);
      chk("stall.zero", {31'd0, rsp_zero}, 32'd0);
      chk("stall.req_ready", {30'd0, req_ready}, 32'd0);
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("stall.4th_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stall.4th_data", rsp_data, 32'd7);
    tick();
    #1;
    chk("stall.done", {31'd0, rsp_valid}, 32'd0);
    chk("stall.next_grant", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;

    req0_op = 4'b1111; req0_a = 32'd9; req0_b = 32'd9;
    txn("illegal", 2'b01, 2'b01, 32'd0, 1'b0, 1'b1);

    // Reset while EXEC: request dropped, pointer back to favouring requester 0.
    req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    #1;
    chk("rstexec.alu_op", {28'd0, alu_op}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstexec.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rstexec.alu_op0", {28'd0, alu_op}, 32'd0);
    chk("rstexec.alu_rd1", alu_rd1, 32'd0);
    chk("rstexec.rsp_data", rsp_data, 32'd0);
    tick();
    #1;
    chk("rstexec.no_stale", {31'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rstexec.tie", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
